message_scheduler: RTL and testbench
====================================

MESSAGE_SCHEDULER -- requirements
Module: message_scheduler

Interface
REQ-001 The block SHALL have no parameters; word width is fixed at 32 and schedule depth at 64.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 start  input  1  request to accept block_in; honoured only while ready=1.
REQ-006 block_in  input  512  padded message block; bit 0 = MSB of word 0.
REQ-007 ready  output  1  idle and able to accept start.
REQ-008 done  output  1  one-cycle pulse: schedule complete.
REQ-009 sched_valid  output  1  message_schedule holds a complete, stable schedule.
REQ-010 message_schedule  output  64 x 32  W[0..63] to the compression stage; bit 0 = MSB of each word.

Function
REQ-011 States SHALL be IDLE, EXPAND and DONE; encoding is free.
REQ-012 IDLE: ready=1; on start=1 at a rising edge, the block SHALL load W[i]=block_in bits [32i:32i+31] for i=0..15, set j=16, clear sched_valid and go to EXPAND.
REQ-013 EXPAND: each rising edge SHALL write W[j]=s1(W[j-2])+W[j-7]+s0(W[j-15])+W[j-16] mod 2^32 and increment j.
REQ-014 s0(x)=ROTR7(x)^ROTR18(x)^SHR3(x); s1(x)=ROTR17(x)^ROTR19(x)^SHR10(x); all adds SHALL truncate to 32 bits.
REQ-015 The edge that writes W[63] SHALL move the FSM to DONE; j SHALL never exceed 63 or wrap to index 0..15.
REQ-016 DONE: done=1 and sched_valid=1 for exactly one cycle; the next edge SHALL return to IDLE.
REQ-017 sched_valid SHALL stay 1 in IDLE until the next start is accepted, then drop to 0 on that accept edge.
REQ-018 Latency: start accepted at edge E0; W[16] written at E1; W[63] written at E48; done=1 during the cycle after E48; 50 cycles from accept to return to IDLE.
REQ-019 ready SHALL be 0 in EXPAND and DONE; start in those states SHALL be ignored, with no queuing.
REQ-020 block_in SHALL be sampled only on the accept edge; later changes SHALL have no effect.
REQ-021 W[0..15] SHALL not change after load until the next accept; W[k] for k>=16 SHALL change only on its own EXPAND edge.
REQ-022 message_schedule SHALL be driven directly from registers with no combinational path from inputs.
REQ-023 A start asserted in the DONE cycle SHALL be ignored; a start in the following IDLE cycle SHALL be accepted, giving back-to-back blocks every 50 cycles.

Reset
REQ-024 On rst=1, asynchronously and in any state, the block SHALL set FSM=IDLE, j=16, W[0..63]=0, done=0 and sched_valid=0; ready SHALL then be 1.
REQ-025 Reset during EXPAND SHALL abandon the partial schedule; done SHALL not be asserted for that block.
REQ-026 A start held high while rst=1 SHALL have no effect; the first accept SHALL be the first rising edge with rst=0, start=1 and ready=1.

Verification
REQ-027 Padded "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018) -> W16=0x61626380, W17=0x000F0000, W63=0x12B1EDEB; done exactly 49 cycles after the accept edge.
REQ-028 All-zero block -> all 64 words = 0x00000000; done pulse is one cycle wide; sched_valid stays 1 until the next start.
REQ-029 Second start pulsed during EXPAND with a different block_in -> ignored; the schedule matches the first block; ready=0 throughout.
REQ-030 rst pulsed at cycle 20 of EXPAND -> all words 0, sched_valid=0, no done pulse; a fresh "abc" block afterwards yields REQ-027 values.
REQ-031 block_in changed every cycle after accept -> the schedule matches the block sampled at accept.
REQ-032 Back-to-back: start held high continuously with two blocks -> second accept 50 cycles after the first; both schedules are correct, and sched_valid drops on the second accept edge.

Source files
------------

// File: rtl/message_scheduler_if.sv
// Handshake and schedule bus between a block source and the message scheduler.
// Vectors use ascending numbering so that bit 0 is the MSB of word 0.
interface message_scheduler_if;
  logic         start;
  logic [0:511] block_in;
  logic         ready;
  logic         done;
  logic         sched_valid;
  logic [0:31]  message_schedule [64];

  modport master (
    output start,
    output block_in,
    input  ready,
    input  done,
    input  sched_valid,
    input  message_schedule
  );

  modport slave (
    input  start,
    input  block_in,
    output ready,
    output done,
    output sched_valid,
    output message_schedule
  );
endinterface

// File: rtl/message_scheduler.sv
// SHA-256 style message schedule: loads 16 words, then expands one word per cycle
// up to W[63], pulsing done for one cycle before returning to idle.
module message_scheduler (
  input  logic                clk,
  input  logic                rst,
  message_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic        schedValid_q, schedValid_d;
  logic [31:0] w_q [64];
  logic        loadBlock;
  logic        writeWord;
  logic [31:0] newWord;

  function automatic logic [31:0] smallSigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] smallSigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign newWord = smallSigma1(w_q[idx_q - 6'd2]) + w_q[idx_q - 6'd7]
                 + smallSigma0(w_q[idx_q - 6'd15]) + w_q[idx_q - 6'd16];

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    schedValid_d = schedValid_q;
    loadBlock    = 1'b0;
    writeWord    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          loadBlock    = 1'b1;
          idx_d        = 6'd16;
          schedValid_d = 1'b0;
          state_d      = EXPAND;
        end
      end
      EXPAND: begin
        writeWord = 1'b1;
        // Index parks at 63 so it never wraps back into the loaded words.
        if (idx_q == 6'd63) begin
          schedValid_d = 1'b1;
          state_d      = DONE;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= 6'd16;
      schedValid_q <= 1'b0;
      for (int i = 0; i < 64; i++) begin
        w_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      schedValid_q <= schedValid_d;
      if (loadBlock) begin
        for (int i = 0; i < 16; i++) begin
          w_q[i] <= bus.block_in[32*i +: 32];
        end
      end else if (writeWord) begin
        w_q[idx_q] <= newWord;
      end
    end
  end

  assign bus.ready       = (state_q == IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.sched_valid = schedValid_q;

  for (genvar g = 0; g < 64; g++) begin : gen_sched_out
    assign bus.message_schedule[g] = w_q[g];
  end

endmodule

// File: tb/tb_message_scheduler.sv
// Bench for message_scheduler: a whole-block schedule model with spec-level timing,
// checked every cycle, plus directed scenarios with literal expectations.
module tb_message_scheduler;

  typedef logic [31:0] sched_t [64];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  message_scheduler_if bus ();

  message_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int     checks    = 0;
  int     errors    = 0;
  int     doneCount = 0;
  bit     checkEn   = 1'b0;

  // Model state: mBusy counts edges since accept (0 = idle, 49 = done cycle).
  int     mBusy;
  logic   mValid;
  sched_t mW;
  sched_t mFull;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic sched_t expandBlock(input logic [0:511] b);
    sched_t w;
    for (int i = 0; i < 16; i++) w[i] = b[32*i +: 32];
    for (int t = 16; t < 64; t++) begin
      w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    end
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mBusy  <= 0;
      mValid <= 1'b0;
      for (int i = 0; i < 64; i++) mW[i] <= '0;
    end else if (mBusy == 0) begin
      if (bus.start) begin
        mFull  <= expandBlock(bus.block_in);
        for (int i = 0; i < 16; i++) mW[i] <= bus.block_in[32*i +: 32];
        mValid <= 1'b0;
        mBusy  <= 1;
      end
    end else if (mBusy <= 48) begin
      mW[15 + mBusy] <= mFull[15 + mBusy];
      if (mBusy == 48) mValid <= 1'b1;
      mBusy <= mBusy + 1;
    end else begin
      mBusy <= 0;
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      int bad;
      checkOutput("ready", {31'd0, bus.ready}, {31'd0, mBusy == 0});
      checkOutput("done", {31'd0, bus.done}, {31'd0, mBusy == 49});
      checkOutput("sched_valid", {31'd0, bus.sched_valid}, {31'd0, mValid});
      bad = -1;
      for (int i = 63; i >= 0; i--) if (bus.message_schedule[i] !== mW[i]) bad = i;
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("[TB] FAIL schedule W[%0d]: got 0x%08h, expected 0x%08h at %0t",
                 bad, bus.message_schedule[bad], mW[bad], $time);
      end
      if (bus.done) doneCount++;
    end
  end

  task automatic applyStimulus(input logic [0:511] b);
    @(negedge clk);
    bus.block_in = b;
    bus.start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  // Counts edges from the accept edge (inclusive) until done is seen.
  task automatic waitDone(output int edges);
    edges = 1;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (bus.done) return;
    end
    checks++;
    errors++;
    $display("[TB] FAIL done timeout: no done within 100 cycles at %0t", $time);
  endtask

  function automatic int nonZeroWords();
    int n = 0;
    for (int i = 0; i < 64; i++) if (bus.message_schedule[i] !== 32'h0) n++;
    return n;
  endfunction

  logic [0:511] abcBlk, blkA, blkB, blkC, blkD;
  sched_t       expA, expD;

  initial begin
    int edges, doneBefore;
    bit sawValid;

    abcBlk = '0;
    abcBlk[0 +: 32]   = 32'h61626380;
    abcBlk[480 +: 32] = 32'h00000018;
    for (int i = 0; i < 16; i++) begin
      blkA[32*i +: 32] = 32'h01234567 * (i + 1);
      blkB[32*i +: 32] = 32'hDEADBEEF ^ i;
      blkC[32*i +: 32] = 32'hA5A5A5A5 + i;
      blkD[32*i +: 32] = 32'h13579BDF * (i + 3);
    end
    expA = expandBlock(blkA);
    expD = expandBlock(blkD);

    // Start held high during reset must not be honoured.
    bus.start    = 1'b1;
    bus.block_in = abcBlk;
    repeat (3) @(negedge clk);
    checkOutput("reset ready", {31'd0, bus.ready}, 32'd1);
    checkOutput("reset done", {31'd0, bus.done}, 32'd0);
    checkOutput("reset sched_valid", {31'd0, bus.sched_valid}, 32'd0);
    checkOutput("reset nonzero words", nonZeroWords(), 32'd0);
    checkEn = 1'b1;
    rst     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("first accept after reset", {31'd0, bus.ready}, 32'd0);
    waitDone(edges);
    checkOutput("abc done latency", edges, 32'd49);
    checkOutput("abc W16", bus.message_schedule[16], 32'h61626380);
    checkOutput("abc W17", bus.message_schedule[17], 32'h000F0000);
    checkOutput("abc W63", bus.message_schedule[63], 32'h12B1EDEB);
    checkOutput("model W63", mFull[63], 32'h12B1EDEB);
    @(negedge clk);
    checkOutput("done pulse width", {31'd0, bus.done}, 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("valid held in idle", {31'd0, bus.sched_valid}, 32'd1);

    applyStimulus('0);
    checkOutput("valid drops on accept", {31'd0, bus.sched_valid}, 32'd0);
    waitDone(edges);
    checkOutput("zero done latency", edges, 32'd49);
    checkOutput("zero nonzero words", nonZeroWords(), 32'd0);
    @(negedge clk);
    checkOutput("zero done pulse width", {31'd0, bus.done}, 32'd0);

    applyStimulus(blkA);
    repeat (10) @(negedge clk);
    bus.block_in = blkB;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    checkOutput("ready during expand", {31'd0, bus.ready}, 32'd0);
    waitDone(edges);
    checkOutput("ignored start W16", bus.message_schedule[16], expA[16]);
    checkOutput("ignored start W63", bus.message_schedule[63], expA[63]);
    repeat (3) @(negedge clk);

    applyStimulus(abcBlk);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid reset sched_valid", {31'd0, bus.sched_valid}, 32'd0);
    checkOutput("mid reset ready", {31'd0, bus.ready}, 32'd1);
    checkOutput("mid reset nonzero words", nonZeroWords(), 32'd0);
    doneBefore = doneCount;
    repeat (60) @(negedge clk);
    checkOutput("no done after reset", doneCount - doneBefore, 32'd0);
    applyStimulus(abcBlk);
    waitDone(edges);
    checkOutput("abc again latency", edges, 32'd49);
    checkOutput("abc again W17", bus.message_schedule[17], 32'h000F0000);
    checkOutput("abc again W63", bus.message_schedule[63], 32'h12B1EDEB);

    applyStimulus(blkA);
    for (int c = 0; c < 55; c++) begin
      @(negedge clk);
      for (int w = 0; w < 16; w++) bus.block_in[32*w +: 32] = $urandom;
    end
    checkOutput("sampled block W0", bus.message_schedule[0], expA[0]);
    checkOutput("sampled block W63", bus.message_schedule[63], expA[63]);

    // Start held high: the second accept must land 50 edges after the first.
    @(negedge clk);
    bus.block_in = blkC;
    bus.start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.block_in = blkD;
    edges    = 1;
    sawValid = 1'b0;
    for (int c = 0; c < 120; c++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (bus.sched_valid) sawValid = 1'b1;
      else if (sawValid) break;
    end
    bus.start = 1'b0;
    checkOutput("back-to-back spacing", edges - 1, 32'd50);
    waitDone(edges);
    checkOutput("second block W16", bus.message_schedule[16], expD[16]);
    checkOutput("second block W63", bus.message_schedule[63], expD[63]);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d errors so far", errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
